// File: rtl/spi_cpu_pkg.sv
// spi_cpu_pkg: shared types and constants for the CPU-side SPI serial SRAM controller
package spi_cpu_pkg;
  localparam int FRAME_BITS = 32;
  localparam int ADDR_W = 16;
  localparam logic [7:0] CMD_READ_DFLT = 8'h03;
  localparam logic [7:0] CMD_WRITE_DFLT = 8'h02;
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, DONE} state_t;
endpackage

// File: rtl/spi_mem_ctrl_if.sv
// spi_mem_ctrl_if: single-byte CPU memory request/response bus
interface spi_mem_ctrl_if;
  import spi_cpu_pkg::*;
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0] req_wdata;
  logic rsp_valid;
  logic [7:0] rsp_rdata;
  logic busy;
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input req_ready, rsp_valid, rsp_rdata, busy
  );
  modport slave (
    input req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/spi_sck_div.sv
// spi_sck_div: SCK half-period divider with registered SCK and edge strobes
module spi_sck_div #(
  parameter int CLK_DIV = 2
) (
  input logic clk,
  input logic rst_n,
  input logic en,
  output logic rise_stb,
  output logic fall_stb,
  output logic sck
);
  localparam int DW = $clog2(CLK_DIV) + 1;
  logic [DW-1:0] cnt;
  logic term;
  // strobes are high in the cycle whose closing edge flips SCK
  assign term = en && cnt == DW'(CLK_DIV - 1);
  assign rise_stb = term && !sck;
  assign fall_stb = term && sck;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (term) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + DW'(1);
    end
  end
endmodule

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: turns CPU byte requests into 32-bit serial SRAM frames (cmd, addr, data), SPI mode 0
module spi_mem_ctrl
  import spi_cpu_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter logic [7:0] CMD_READ = CMD_READ_DFLT,
  parameter logic [7:0] CMD_WRITE = CMD_WRITE_DFLT
) (
  input logic clk,
  input logic rst_n,
  spi_mem_ctrl_if.slave cpu,
  output logic spi_cs_n,
  output logic spi_sck,
  output logic spi_mosi,
  input logic spi_miso
);
  localparam int DW = $clog2(CLK_DIV) + 1;
  state_t state;
  logic [FRAME_BITS-1:0] frame;
  logic [FRAME_BITS-1:0] new_frame;
  logic [7:0] rx;
  logic [7:0] rdata;
  logic [4:0] bit_cnt;
  logic [DW-1:0] hold_cnt;
  logic we;
  logic rsp_valid;
  logic rise_stb;
  logic fall_stb;
  spi_sck_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk(clk),
    .rst_n(rst_n),
    .en(state == SHIFT),
    .rise_stb(rise_stb),
    .fall_stb(fall_stb),
    .sck(spi_sck)
  );
  assign new_frame = {cpu.req_we ? CMD_WRITE : CMD_READ, cpu.req_addr, cpu.req_we ? cpu.req_wdata : 8'h00};
  assign cpu.req_ready = state == IDLE;
  assign cpu.busy = state != IDLE;
  assign cpu.rsp_valid = rsp_valid;
  assign cpu.rsp_rdata = rdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      frame <= '0;
      rx <= '0;
      rdata <= '0;
      bit_cnt <= '0;
      hold_cnt <= '0;
      we <= 1'b0;
      rsp_valid <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_mosi <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cpu.req_valid) begin
          frame <= new_frame;
          we <= cpu.req_we;
          spi_mosi <= new_frame[FRAME_BITS-1];
          spi_cs_n <= 1'b0;
          state <= SHIFT;
        end
        SHIFT: begin
          if (rise_stb) rx <= {rx[6:0], spi_miso};
          if (fall_stb) begin
            frame <= frame << 1;
            spi_mosi <= bit_cnt == 5'd31 ? 1'b0 : frame[FRAME_BITS-2];
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd31) begin
              hold_cnt <= '0;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          hold_cnt <= hold_cnt + DW'(1);
          if (hold_cnt == DW'(CLK_DIV - 1)) begin
            spi_cs_n <= 1'b1;
            rsp_valid <= 1'b1;
            rdata <= we ? rdata : rx;
            state <= DONE;
          end
        end
        DONE: begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb_spi_mem_ctrl: table, random and corner-case checks against a behavioural serial SRAM and request model
module tb_spi_mem_ctrl;
  import spi_cpu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  spi_mem_ctrl_if bus0 ();
  spi_mem_ctrl_if bus1 ();
  wire [1:0] cs_n, sck, mosi, miso;
  spi_mem_ctrl #(.CLK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .cpu(bus0.slave),
    .spi_cs_n(cs_n[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0])
  );
  spi_mem_ctrl #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cpu(bus1.slave),
    .spi_cs_n(cs_n[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1])
  );
  int checks = 0;
  int errors = 0;
  logic [7:0] prev_rd;
  logic [7:0] ref_mem [logic [15:0]];
  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a == 16'h1234 ? 8'hA5 : a == 16'hFFFF ? 8'h5A : a[7:0] ^ a[15:8] ^ 8'h96;
  endfunction
  function automatic logic [7:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction
  // serial SRAM slave: shifts MOSI on SCK rise, answers reads MSB first, records each frame at CS rise
  for (genvar g = 0; g < 2; g++) begin : m
    logic [7:0] mem [logic [15:0]];
    logic [31:0] sr = '0;
    logic [31:0] last_frame = '0;
    logic [7:0] rcmd = '0;
    logic [7:0] rbyte = '0;
    logic [15:0] ra = '0;
    logic miso_r = 1'b0;
    int nbits = 0;
    int last_bits = 0;
    int bad_sck = 0;
    assign miso[g] = miso_r;
    always @(posedge sck[g] or posedge cs_n[g]) begin
      if (cs_n[g]) begin
        if (sck[g]) bad_sck++;
        else begin
          last_frame = sr;
          last_bits = nbits;
          nbits = 0;
          miso_r = 1'b0;
        end
      end else begin
        sr = {sr[30:0], mosi[g]};
        nbits++;
        if (nbits == 24) begin
          rcmd = sr[23:16];
          ra = sr[15:0];
          rbyte = mem.exists(ra) ? mem[ra] : init_byte(ra);
        end
        miso_r = (nbits >= 24 && nbits < 32 && rcmd == 8'h03) ? rbyte[31-nbits] : 1'b0;
        if (nbits == 32 && sr[31:24] == 8'h02) mem[sr[23:8]] = sr[7:0];
      end
    end
  end
  typedef struct {
    logic we;
    logic [15:0] a;
    logic [7:0] d;
    logic [31:0] frame;
    logic [7:0] rd;
  } vec_t;
  vec_t tv [6];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic op0(input logic we, input logic [15:0] a, input logic [7:0] d,
                     input logic [31:0] exp_frame, input logic [7:0] exp_rd, input bit noise);
    int lat;
    int bad;
    int cs_low;
    bit got;
    @(negedge clk);
    bus0.req_valid = 1'b1;
    bus0.req_we = we;
    bus0.req_addr = a;
    bus0.req_wdata = d;
    lat = 0;
    while (!bus0.req_ready && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    check("ready_idle", 32'(bus0.req_ready), 1);
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;
    check("accept_state", {bus0.busy, bus0.req_ready, cs_n[0]}, 3'b100);
    lat = 1;
    got = 0;
    bad = 0;
    while (!got && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus0.rsp_valid) got = 1;
      else begin
        if (bus0.req_ready || !bus0.busy || cs_n[0]) bad++;
        if (noise) begin
          bus0.req_valid = 1'($urandom);
          bus0.req_we = 1'($urandom);
          bus0.req_addr = 16'($urandom);
          bus0.req_wdata = 8'($urandom);
        end
      end
    end
    bus0.req_valid = 1'b0;
    check("rsp_seen", 32'(got), 1);
    check("latency", lat, 131);
    check("rdata", bus0.rsp_rdata, exp_rd);
    check("mosi_frame", m[0].last_frame, exp_frame);
    check("sck_rises", m[0].last_bits, 32);
    check("inflight_state", bad, 0);
    check("done_state", {cs_n[0], bus0.busy}, 2'b11);
    @(posedge clk);
    #1;
    check("after_done", {bus0.rsp_valid, bus0.busy, bus0.req_ready, cs_n[0]}, 4'b0011);
    if (we) ref_mem[a] = d;
    prev_rd = exp_rd;
    if (noise) begin
      cs_low = 0;
      repeat (10) begin
        @(posedge clk);
        #1;
        cs_low += 32'(!cs_n[0]);
      end
      check("no_extra_frame", cs_low, 0);
    end
  endtask
  initial begin
    int n;
    int lat;
    int hi;
    int stuck;
    int rv;
    bit got;
    logic prevs;
    logic we;
    logic [15:0] a;
    logic [7:0] d;
    bus0.req_valid = 0; bus0.req_we = 0; bus0.req_addr = 0; bus0.req_wdata = 0;
    bus1.req_valid = 0; bus1.req_we = 0; bus1.req_addr = 0; bus1.req_wdata = 0;
    tv[0] = '{1'b0, 16'h1234, 8'h00, 32'h03123400, 8'hA5};
    tv[1] = '{1'b1, 16'hBEEF, 8'h3C, 32'h02BEEF3C, 8'hA5};
    tv[2] = '{1'b0, 16'hBEEF, 8'h99, 32'h03BEEF00, 8'h3C};
    tv[3] = '{1'b1, 16'h0000, 8'hFF, 32'h020000FF, 8'h3C};
    tv[4] = '{1'b0, 16'h0000, 8'h00, 32'h03000000, 8'hFF};
    tv[5] = '{1'b0, 16'hFFFF, 8'h00, 32'h03FFFF00, 8'h5A};
    prev_rd = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pins", {cs_n, sck, mosi}, 6'b110000);
    check("reset_bus", {bus0.rsp_valid, bus0.busy, bus0.req_ready}, 3'b001);
    check("reset_rdata", bus0.rsp_rdata, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) op0(tv[i].we, tv[i].a, tv[i].d, tv[i].frame, tv[i].rd, 0);
    op0(1'b0, 16'h4242, 8'h00, 32'h03424200, ref_read(16'h4242), 1);
    // back-to-back: write then read held high across DONE
    @(negedge clk);
    bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_addr = 16'h0010; bus0.req_wdata = 8'h77;
    @(posedge clk);
    #1;
    bus0.req_we = 1'b0;
    bus0.req_wdata = 8'h00;
    n = 0;
    while (!bus0.rsp_valid && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b2b_first_rsp", 32'(bus0.rsp_valid), 1);
    check("b2b_first_frame", m[0].last_frame, 32'h02001077);
    n = 0;
    while (cs_n[0] && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus0.req_valid = 1'b0;
    check("b2b_cs_gap", n, 2);
    n = 0;
    while (!bus0.rsp_valid && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b2b_second_lat", n + 1, 131);
    check("b2b_rdata", bus0.rsp_rdata, 8'h77);
    check("b2b_second_frame", m[0].last_frame, 32'h03001000);
    ref_mem[16'h0010] = 8'h77;
    prev_rd = 8'h77;
    @(posedge clk);
    for (int i = 0; i < 30; i++) begin
      we = 1'($urandom);
      a = $urandom_range(0, 3) != 0 ? {12'h000, 4'($urandom)} : 16'($urandom);
      d = 8'($urandom);
      op0(we, a, d, {we ? 8'h02 : 8'h03, a, we ? d : 8'h00}, we ? prev_rd : ref_read(a), 0);
    end
    // asynchronous reset in the middle of a read frame
    @(negedge clk);
    bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.req_addr = 16'h0777;
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;
    n = 0;
    while (m[0].nbits < 12 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("rst_at_bit12", m[0].nbits, 12);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async_pins", {cs_n[0], sck[0], mosi[0]}, 3'b100);
    check("rst_async_bus", {bus0.busy, bus0.req_ready, bus0.rsp_valid}, 3'b010);
    check("rst_rdata", bus0.rsp_rdata, 8'h00);
    rv = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      rv += 32'(bus0.rsp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      rv += 32'(bus0.rsp_valid) + 32'(!cs_n[0]);
    end
    check("rst_no_rsp", rv, 0);
    prev_rd = 8'h00;
    op0(1'b0, 16'h0001, 8'h00, 32'h03000100, ref_read(16'h0001), 0);
    // CLK_DIV=1 instance
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_addr = 16'hFFFF;
    @(posedge clk);
    #1;
    bus1.req_valid = 1'b0;
    lat = 1;
    got = 0;
    hi = 32'(sck[1]);
    stuck = 0;
    prevs = sck[1];
    while (!got && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus1.rsp_valid) got = 1;
      else if (!cs_n[1]) begin
        if (sck[1] == prevs) stuck++;
        prevs = sck[1];
        hi += 32'(sck[1]);
      end
    end
    check("div1_rsp_seen", 32'(got), 1);
    check("div1_latency", lat, 66);
    check("div1_rdata", bus1.rsp_rdata, 8'h5A);
    check("div1_frame", m[1].last_frame, 32'h03FFFF00);
    check("div1_sck_high", hi, 32);
    check("div1_sck_period", stuck, 0);
    check("div1_sck_rises", m[1].last_bits, 32);
    check("sck_while_cs_high", m[0].bad_sck + m[1].bad_sck, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_mem_ctrl.md
Name: spi_mem_ctrl

Overview:
SPI master sitting directly between the CPU core and the uio SPI pins; it converts single-byte CPU memory requests into 23LC512-style serial SRAM transactions. Each request becomes one 32-bit frame: 8-bit command, 16-bit address, 8-bit data. The block drives CS/SCK/MOSI, samples MISO, and returns read data or a write acknowledge to the core.

Parameters:
CLK_DIV, 2, SCK half-period in clk cycles; legal range >= 1.
CMD_READ, 8'h03, serial SRAM read command.
CMD_WRITE, 8'h02, serial SRAM write command.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  CPU request strobe
req_ready  output  1  high when a request can be accepted
req_we  input  1  1 = write, 0 = read
req_addr  input  16  byte address
req_wdata  input  8  write data
rsp_valid  output  1  one-cycle completion pulse, for reads and writes
rsp_rdata  output  8  read data; valid with rsp_valid on reads
busy  output  1  high from acceptance through the rsp_valid cycle
spi_cs_n  output  1  chip select, active low
spi_sck  output  1  serial clock, mode 0, idle low
spi_mosi  output  1  serial data out, MSB first
spi_miso  input  1  serial data in

Behaviour:
- Reset (async, rst_n=0): state IDLE; spi_cs_n=1, spi_sck=0, spi_mosi=0, rsp_valid=0, rsp_rdata=8'h00, busy=0, req_ready=1. Reset mid-frame aborts immediately: CS deasserts with no response.
- req_ready = (state==IDLE), combinational from state only. Acceptance occurs on a clk edge with req_valid && req_ready.
- At acceptance, latch frame = {req_we ? CMD_WRITE : CMD_READ, req_addr, req_we ? req_wdata : 8'h00} and the latched we. Input changes after acceptance are ignored.
- States:
  - IDLE -> SHIFT on acceptance.
  - SHIFT -> HOLD after 32 bits.
  - HOLD -> DONE after CLK_DIV cycles.
  - DONE -> IDLE after 1 cycle.
- SHIFT: spi_cs_n=0 from the first SHIFT cycle. Each bit lasts 2*CLK_DIV cycles:
  - CLK_DIV cycles with SCK low and MOSI = current frame MSB;
  - then CLK_DIV cycles with SCK high.
  - MISO is sampled into the rx shift register on the clk edge that drives SCK 0->1.
  - The frame shifts left when SCK goes 1->0. After the 32nd high phase, SCK returns low and the state enters HOLD.
- HOLD: CS low, SCK low, MOSI 0, for CLK_DIV cycles (CS hold time).
- DONE: spi_cs_n=1, rsp_valid=1 for exactly one cycle, busy=1.
  - Reads: rsp_rdata = last 8 sampled MISO bits (frame bits 7:0), MSB first.
  - Writes: rsp_rdata holds its previous value.
- Latency: rsp_valid is high on the 65*CLK_DIV+1-th cycle after the accepting edge. CLK_DIV=2 gives 131 cycles.
- Exactly 32 SCK rising edges per frame. SCK never toggles while CS is high.
- Back-to-back: a request held during DONE is accepted in the following IDLE cycle. Minimum CS-high time is 2 clk cycles.
- req_valid while busy: ignored, no side effects. The core must hold it until req_ready.
- MOSI, SCK and CS are driven from flops only (glitch-free pins).
- Bit counter is 5 bits, wrapping 31->0 only on the SHIFT->HOLD exit. The divider counter is sized $clog2(CLK_DIV)+1.

Decomposition:
- Shared package spi_cpu_pkg:
  - state enum (IDLE, SHIFT, HOLD, DONE);
  - FRAME_BITS=32;
  - CMD_READ and CMD_WRITE defaults;
  - ADDR_W=16.
- One sub-module, spi_sck_div: the CLK_DIV counter that emits one-cycle rise_stb/fall_stb and the registered SCK level, enabled only in SHIFT.
- The FSM, shift registers and handshake stay in spi_mem_ctrl.

Test Plan:
- Read: req_we=0, addr=16'h1234; the SRAM model returns 8'hA5. Required: MOSI stream 32'h03123400; 32 SCK rising edges; rsp_rdata=8'hA5; rsp_valid one cycle at 131 cycles (CLK_DIV=2); CS high afterwards.
- Write: req_we=1, addr=16'hBEEF, wdata=8'h3C. Required: MOSI stream 32'h02BEEF3C; the model stores 3C at BEEF; rsp_valid pulses; rsp_rdata unchanged.
- Back-to-back: write 16'h0010 <= 8'h77, then read 16'h0010 with req_valid held high. Required: the second frame starts 2 cycles after the first CS rise; rsp_rdata=8'h77.
- Mid-frame changes: change req_addr/req_wdata and pulse req_valid during SHIFT. Required: frame contents unaffected; no extra transaction; req_ready=0 throughout.
- Reset mid-frame: assert rst_n=0 at bit 12. Required: cs_n=1, sck=0, mosi=0 asynchronously; no rsp_valid; after release a fresh read of 16'h0001 completes normally.
- CLK_DIV=1 build: read 16'hFFFF with the model returning 8'h5A. Required: SCK period 2 cycles; rsp_valid at cycle 66; rsp_rdata=8'h5A.
